// File: rtl/cordic_arbiter_if.sv
// Bus bundle for cordic_arbiter.
// Groups three sets of signals:
//   - the requester side: valid/ready handshake plus the packed mode and operand fields;
//   - the CORDIC datapath side: operands out to the pipe and results back from it;
//   - the response side: valid/ready handshake plus the result fields, and busy.
// Modports:
//   slave  - the arbiter's view of the bundle.
//   master - the environment's view: requesters, CORDIC pipe and response consumer together.
interface cordic_arbiter_if #(
    parameter int unsigned W    = 16,
    parameter int unsigned NREQ = 2
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Requester side, one lane per requester; operand lane i sits at [i*W +: W]
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_m;
    logic [NREQ-1:0]   req_rot_vec;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ*W-1:0] req_z;

    // CORDIC datapath side
    logic              cor_m;
    logic              cor_rot_vec;
    logic [W-1:0]      cor_xin;
    logic [W-1:0]      cor_yin;
    logic [W-1:0]      cor_zin;
    logic [W-1:0]      cor_xout;
    logic [W-1:0]      cor_yout;
    logic [W-1:0]      cor_zout;

    // Response side
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_x;
    logic [W-1:0]      rsp_y;
    logic [W-1:0]      rsp_z;
    logic              busy;

    modport slave (
        input  req_valid, req_m, req_rot_vec, req_x, req_y, req_z,
        output req_ready,
        output cor_m, cor_rot_vec, cor_xin, cor_yin, cor_zin,
        input  cor_xout, cor_yout, cor_zout,
        output rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, busy,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_m, req_rot_vec, req_x, req_y, req_z,
        input  req_ready,
        input  cor_m, cor_rot_vec, cor_xin, cor_yin, cor_zin,
        output cor_xout, cor_yout, cor_zout,
        input  rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, busy,
        output rsp_ready
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Shares one fully pipelined CORDIC datapath between NREQ requesters.
// Behaviour:
//   - Round-robin grants, at most one per cycle.
//   - A {valid, id} tag pipe runs alongside the CORDIC pipe, LAT stages deep.
//   - Finished results are collected in a DEPTH-entry FIFO.
//   - A credit counter bounds in-flight ops plus FIFO occupancy by DEPTH, so the FIFO
//     never overflows.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active high
//   bus  - slave modport of cordic_arbiter_if:
//            requester handshake and operands in, CORDIC operands out and results in,
//            response handshake and result out, busy out
module cordic_arbiter #(
    parameter int unsigned W     = 16,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned LAT   = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    cordic_arbiter_if.slave bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Arbitration and credits
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pop, issue_ok, grant_any;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid, cand;

    // Tag pipe, stage LAT-1 lines up with cor_*out
    logic            tag_vld_q [LAT];
    logic [IDW-1:0]  tag_id_q  [LAT];

    // Result FIFO
    logic [IDW-1:0]  mem_id [DEPTH];
    logic [W-1:0]    mem_x  [DEPTH];
    logic [W-1:0]    mem_y  [DEPTH];
    logic [W-1:0]    mem_z  [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic            push, rsp_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rsp_valid = (fill_q != '0);
    assign pop       = rsp_valid & bus.rsp_ready;
    assign push      = tag_vld_q[LAT-1];

    // A pop this cycle frees a credit, so a full counter can still issue alongside it
    assign issue_ok  = ({1'b0, cnt_q} - {{CW{1'b0}}, pop}) < (CW+1)'(DEPTH);

    // Round-robin search starting just after the last winner
    always_comb begin
        grant     = '0;
        gid       = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (issue_ok) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
                if (!grant_any && bus.req_valid[cand]) begin
                    grant_any = 1'b1;
                    gid       = cand;
                end
            end
        end
        if (grant_any) begin
            grant[gid] = 1'b1;
        end
    end

    assign bus.req_ready = grant;
    assign rr_ptr_d      = grant_any ? gid : rr_ptr_q;
    assign cnt_d         = cnt_q + CW'(grant_any) - CW'(pop);

    // Operand mux; all zero when nothing is granted
    always_comb begin
        bus.cor_m       = 1'b0;
        bus.cor_rot_vec = 1'b0;
        bus.cor_xin     = '0;
        bus.cor_yin     = '0;
        bus.cor_zin     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                bus.cor_m       = bus.req_m[i];
                bus.cor_rot_vec = bus.req_rot_vec[i];
                bus.cor_xin     = bus.req_x[i*W +: W];
                bus.cor_yin     = bus.req_y[i*W +: W];
                bus.cor_zin     = bus.req_z[i*W +: W];
            end
        end
    end

    assign wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    assign fill_d   = fill_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= IDW'(NREQ - 1);
            cnt_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_vld_q[0] <= grant_any;
            tag_id_q[0]  <= gid;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    // Storage needs no reset; fill_q alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr_q] <= tag_id_q[LAT-1];
            mem_x[wr_ptr_q]  <= bus.cor_xout;
            mem_y[wr_ptr_q]  <= bus.cor_yout;
            mem_z[wr_ptr_q]  <= bus.cor_zout;
        end
    end

    // Credits should make an overflowing push impossible
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (fill_q == CW'(DEPTH))));
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = mem_id[rd_ptr_q];
    assign bus.rsp_x     = mem_x[rd_ptr_q];
    assign bus.rsp_y     = mem_y[rd_ptr_q];
    assign bus.rsp_z     = mem_z[rd_ptr_q];
    assign bus.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter.
// Two instances are used:
//   - DUT A (DEPTH=8) is compared every cycle against a queue-based reference model.
//     It runs directed sequences and a randomized phase.
//   - DUT B (DEPTH=4) runs a table of per-cycle vectors for the credit-stall cases.
// A stand-in CORDIC pipe with LAT stages computes a simple operand function that the
// model shares.
module tb_cordic_arbiter;
    localparam int unsigned W       = 16;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned LAT     = 8;
    localparam int unsigned DEPTH_A = 8;
    localparam int unsigned DEPTH_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    cordic_arbiter_if #(.W(W), .NREQ(NREQ)) bus_a ();
    cordic_arbiter_if #(.W(W), .NREQ(NREQ)) bus_b ();

    cordic_arbiter #(.W(W), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH_A)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    cordic_arbiter #(.W(W), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH_B)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Stand-in CORDIC function
    function automatic logic [3*W-1:0] cfn(input logic m, input logic rv,
                                           input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] z);
        logic [W-1:0] xo, yo, zo;
        xo = x + y + W'(m);
        yo = y - z;
        zo = z ^ x ^ {rv, {(W-1){1'b0}}};
        return {xo, yo, zo};
    endfunction

    logic [3*W-1:0] pipe_a [LAT];
    logic [3*W-1:0] pipe_b [LAT];
    always @(posedge clk) begin
        pipe_a[0] <= cfn(bus_a.cor_m, bus_a.cor_rot_vec, bus_a.cor_xin, bus_a.cor_yin,
                         bus_a.cor_zin);
        pipe_b[0] <= cfn(bus_b.cor_m, bus_b.cor_rot_vec, bus_b.cor_xin, bus_b.cor_yin,
                         bus_b.cor_zin);
        for (int i = 1; i < LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign bus_a.cor_xout = pipe_a[LAT-1][3*W-1:2*W];
    assign bus_a.cor_yout = pipe_a[LAT-1][2*W-1:W];
    assign bus_a.cor_zout = pipe_a[LAT-1][W-1:0];
    assign bus_b.cor_xout = pipe_b[LAT-1][3*W-1:2*W];
    assign bus_b.cor_yout = pipe_b[LAT-1][2*W-1:W];
    assign bus_b.cor_zout = pipe_b[LAT-1][W-1:0];

    // Requester state for DUT A
    logic [NREQ-1:0] v;
    logic [W-1:0]    ox [NREQ];
    logic [W-1:0]    oy [NREQ];
    logic [W-1:0]    oz [NREQ];
    logic            om [NREQ];
    logic            orv [NREQ];
    assign bus_a.req_valid   = v;
    assign bus_a.req_x       = {ox[1], ox[0]};
    assign bus_a.req_y       = {oy[1], oy[0]};
    assign bus_a.req_z       = {oz[1], oz[0]};
    assign bus_a.req_m       = {om[1], om[0]};
    assign bus_a.req_rot_vec = {orv[1], orv[0]};

    // Reference model: results in flight with their due cycle, then an ordered result queue
    typedef struct { int id; logic [W-1:0] x; logic [W-1:0] y; logic [W-1:0] z; } res_t;
    typedef struct { int due; res_t r; } fly_t;
    res_t m_fifo [$];
    fly_t m_fly [$];
    int   m_cnt, m_last, m_gnt, mcyc;

    // Values sampled by the last step, plus count of observed DUT pops
    int s_ready, s_rsp_valid, s_rsp_id, s_rsp_x, s_rsp_y, s_rsp_z, s_busy, s_fire;

    task automatic model_reset();
        m_fifo.delete();
        m_fly.delete();
        m_cnt  = 0;
        m_last = int'(NREQ) - 1;
        m_gnt  = -1;
    endtask

    task automatic step_a();
        int             win;
        int             idx;
        logic           pop;
        logic [3*W-1:0] f;
        fly_t           fl;
        res_t           r;
        @(negedge clk);
        s_ready     = int'(bus_a.req_ready);
        s_rsp_valid = int'(bus_a.rsp_valid);
        s_rsp_id    = int'(bus_a.rsp_id);
        s_rsp_x     = int'(bus_a.rsp_x);
        s_rsp_y     = int'(bus_a.rsp_y);
        s_rsp_z     = int'(bus_a.rsp_z);
        s_busy      = int'(bus_a.busy);
        if (bus_a.rsp_valid && bus_a.rsp_ready) s_fire++;
        pop = (m_fifo.size() > 0) && bus_a.rsp_ready;
        chk("rsp_valid", s_rsp_valid, int'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            chk("rsp_id", s_rsp_id, m_fifo[0].id);
            chk("rsp_x", s_rsp_x, int'(m_fifo[0].x));
            chk("rsp_y", s_rsp_y, int'(m_fifo[0].y));
            chk("rsp_z", s_rsp_z, int'(m_fifo[0].z));
        end
        chk("busy", s_busy, int'(m_cnt != 0));
        win = -1;
        if (m_cnt - int'(pop) < int'(DEPTH_A)) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                idx = (m_last + k) % int'(NREQ);
                if (win < 0 && v[idx]) win = idx;
            end
        end
        chk("req_ready", s_ready, (win >= 0) ? (1 << win) : 0);
        if (win >= 0) begin
            chk("cor_xin", int'(bus_a.cor_xin), int'(ox[win]));
            chk("cor_yin", int'(bus_a.cor_yin), int'(oy[win]));
            chk("cor_zin", int'(bus_a.cor_zin), int'(oz[win]));
            chk("cor_mode", int'({bus_a.cor_m, bus_a.cor_rot_vec}), int'({om[win], orv[win]}));
            f      = cfn(om[win], orv[win], ox[win], oy[win], oz[win]);
            fl.due = mcyc + int'(LAT);
            fl.r   = '{id: win, x: f[3*W-1:2*W], y: f[2*W-1:W], z: f[W-1:0]};
            m_fly.push_back(fl);
            m_cnt++;
            m_last = win;
        end else begin
            chk("cor_idle", int'({bus_a.cor_m, bus_a.cor_rot_vec}) | int'(bus_a.cor_xin) |
                int'(bus_a.cor_yin) | int'(bus_a.cor_zin), 0);
        end
        if (pop) begin
            r = m_fifo.pop_front();
            m_cnt--;
        end
        while (m_fly.size() > 0 && m_fly[0].due == mcyc) begin
            fl = m_fly.pop_front();
            m_fifo.push_back(fl.r);
        end
        m_gnt = win;
        mcyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        v     = '0;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        model_reset();
    endtask

    task automatic rand_op(input int i);
        ox[i]  = W'($urandom);
        oy[i]  = W'($urandom);
        oz[i]  = W'($urandom);
        om[i]  = 1'($urandom);
        orv[i] = 1'($urandom);
    endtask

    typedef struct { logic v; logic rr; logic exp_rdy; logic exp_rv; logic exp_busy; } vec_t;
    vec_t tab [19];

    initial begin
        int first_rv;
        int ids [$];
        int t2_exp [6];
        int issued;
        int gcount;
        int pat [4];

        // DUT B table: req0 always valid, consumer stalled except for one pop at row 16
        for (int i = 0; i < 19; i++) begin
            tab[i].v        = 1'b1;
            tab[i].rr       = (i == 16);
            tab[i].exp_rdy  = (i < 4) || (i == 16);
            tab[i].exp_rv   = (i >= 9);
            tab[i].exp_busy = (i >= 1);
        end
        t2_exp = '{1, 2, 1, 2, 1, 2};
        pat    = '{1, 0, 0, 1};

        rst_a = 1'b1;
        rst_b = 1'b1;
        v     = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            ox[i] = '0; oy[i] = '0; oz[i] = '0; om[i] = 1'b0; orv[i] = 1'b0;
        end
        bus_a.rsp_ready   = 1'b0;
        bus_b.rsp_ready   = 1'b0;
        bus_b.req_valid   = '0;
        bus_b.req_m       = '0;
        bus_b.req_rot_vec = '0;
        bus_b.req_x       = {16'h1111, 16'h0400};
        bus_b.req_y       = {16'h2222, 16'h0300};
        bus_b.req_z       = {16'h3333, 16'h0200};
        mcyc   = 0;
        s_fire = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;

        // T1: single op, check latency and data
        ox[0] = 16'h2000; oy[0] = 16'h0000; oz[0] = 16'h1000; om[0] = 1'b0; orv[0] = 1'b0;
        v[0]  = 1'b1;
        bus_a.rsp_ready = 1'b1;
        first_rv = -1;
        for (int c = 0; c < int'(LAT) + 4; c++) begin
            step_a();
            if (c == 0) begin
                chk("t1_ready", s_ready, 1);
                v[0] = 1'b0;
            end
            if (s_rsp_valid != 0 && first_rv < 0) begin
                first_rv = c;
                chk("t1_id", s_rsp_id, 0);
                chk("t1_x", s_rsp_x, 'h2000);
                chk("t1_y", s_rsp_y, 'hF000);
                chk("t1_z", s_rsp_z, 'h3000);
            end
        end
        chk("t1_latency", first_rv, int'(LAT) + 1);

        // T2: contention, strict alternation starting at req0
        reset_a();
        rand_op(0);
        rand_op(1);
        v = 2'b11;
        for (int c = 0; c < 6; c++) begin
            step_a();
            chk("t2_grant", s_ready, t2_exp[c]);
            if (m_gnt >= 0) rand_op(m_gnt);
        end
        v = '0;
        for (int c = 0; c < 14; c++) begin
            step_a();
            if (s_rsp_valid != 0) ids.push_back(s_rsp_id);
        end
        chk("t2_count", ids.size(), 6);
        for (int i = 0; i < ids.size() && i < 6; i++) chk("t2_id_order", ids[i], i % 2);

        // T5: reset with three ops in flight
        reset_a();
        rand_op(0);
        v[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step_a();
            if (m_gnt == 0) rand_op(0);
            if (c == 2) v[0] = 1'b0;
        end
        reset_a();
        for (int c = 0; c < int'(LAT) + 2; c++) begin
            step_a();
            chk("t5_quiet", s_rsp_valid, 0);
            chk("t5_busy", s_busy, 0);
        end
        rand_op(0);
        rand_op(1);
        v = 2'b11;
        step_a();
        chk("t5_first_grant", s_ready, 1);

        // T6: toggling backpressure over 16 ops
        reset_a();
        s_fire = 0;
        issued = 0;
        rand_op(0);
        rand_op(1);
        v = 2'b11;
        for (int c = 0; c < 400 && (issued < 16 || m_cnt > 0); c++) begin
            bus_a.rsp_ready = pat[c % 4][0];
            step_a();
            if (m_gnt >= 0) begin
                issued++;
                if (issued + int'(v[0]) + int'(v[1]) - 1 < 16) rand_op(m_gnt);
                else v[m_gnt] = 1'b0;
            end
        end
        chk("t6_issued", issued, 16);
        chk("t6_popped", s_fire, 16);
        chk("t6_drained", m_cnt, 0);

        // Randomized traffic and backpressure
        reset_a();
        for (int c = 0; c < 400; c++) begin
            bus_a.rsp_ready = ($urandom_range(99) < 65);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (v[i] == 1'b0 && $urandom_range(99) < 55) begin
                    rand_op(i);
                    v[i] = 1'b1;
                end
            end
            step_a();
            if (m_gnt >= 0) begin
                rand_op(m_gnt);
                v[m_gnt] = ($urandom_range(99) < 50);
            end
        end
        v = '0;

        // T3/T4 on DUT B: credit stall at DEPTH=4, then pop and grant together
        @(posedge clk);
        #1;
        rst_b  = 1'b0;
        gcount = 0;
        for (int i = 0; i < 19; i++) begin
            bus_b.req_valid = {1'b0, tab[i].v};
            bus_b.rsp_ready = tab[i].rr;
            @(negedge clk);
            chk("t3_ready", int'(bus_b.req_ready), int'(tab[i].exp_rdy));
            chk("t3_rsp_valid", int'(bus_b.rsp_valid), int'(tab[i].exp_rv));
            chk("t3_busy", int'(bus_b.busy), int'(tab[i].exp_busy));
            if (bus_b.rsp_valid) chk("t3_rsp_id", int'(bus_b.rsp_id), 0);
            if (bus_b.req_ready[0]) gcount++;
            if (i == 15) chk("t3_grants_before_pop", gcount, 4);
            @(posedge clk);
            #1;
        end
        chk("t4_grants_total", gcount, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
